// File: rtl/rotate_controller.sv
// rtl/rotate_controller.sv - Moore FSM sequencing the rotate datapath counters and write strobes
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       begin an operation (sampled only in IDLE)
//   abort       cancel the operation in progress (ignored in IDLE)
//   cnt_co_64   terminal count of the datapath slice counter (used in ROT only)
//   cnt_co_25   terminal count of the datapath lane counter (used in LANE only)
//   cnt_rst_64  slice counter reset        cnt_en_64  slice counter enable
//   cnt_rst_25  lane counter reset         cnt_en_25  lane counter enable
//   inreg_en    datapath input-register load
//   wr_en_1     per-slice memory write strobe
//   wr_en_2     per-lane memory write strobe
//   busy        any state other than IDLE
//   done        one-cycle completion pulse
module rotate_controller #(
  parameter int ROUNDS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic cnt_co_64,
  input  logic cnt_co_25,
  output logic cnt_rst_64,
  output logic cnt_rst_25,
  output logic cnt_en_64,
  output logic cnt_en_25,
  output logic inreg_en,
  output logic wr_en_1,
  output logic wr_en_2,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_ROT,
    S_LANE,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [4:0] ROUNDS_W = 5'(ROUNDS);

  state_t     state, state_nxt;
  logic [4:0] round_cnt, round_nxt;
  logic [4:0] round_inc;

  assign round_inc = round_cnt + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      round_cnt <= '0;
    end else begin
      state     <= state_nxt;
      round_cnt <= round_nxt;
    end
  end

  // Outputs depend only on the current state; inputs only steer the next state.
  always_comb begin
    state_nxt  = state;
    round_nxt  = round_cnt;
    cnt_rst_64 = 1'b0;
    cnt_rst_25 = 1'b0;
    cnt_en_64  = 1'b0;
    cnt_en_25  = 1'b0;
    inreg_en   = 1'b0;
    wr_en_1    = 1'b0;
    wr_en_2    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_INIT;
      end
      S_INIT: begin
        busy       = 1'b1;
        cnt_rst_64 = 1'b1;
        cnt_rst_25 = 1'b1;
        round_nxt  = '0;
        state_nxt  = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        inreg_en  = 1'b1;
        state_nxt = S_ROT;
      end
      S_ROT: begin
        busy      = 1'b1;
        wr_en_1   = 1'b1;
        cnt_en_64 = 1'b1;
        if (cnt_co_64) state_nxt = S_LANE;
      end
      S_LANE: begin
        busy       = 1'b1;
        wr_en_2    = 1'b1;
        cnt_en_25  = 1'b1;
        cnt_rst_64 = 1'b1;
        state_nxt  = cnt_co_25 ? S_ROUND : S_LOAD;
      end
      S_ROUND: begin
        busy       = 1'b1;
        cnt_rst_25 = 1'b1;
        round_nxt  = round_inc;
        // Decide on the incremented value so the final round ends here, not one pass later.
        state_nxt  = (round_inc == ROUNDS_W) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides every transition but has no meaning while idle.
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

endmodule

// File: tb/tb_rotate_controller.sv
// tb/tb_rotate_controller.sv - self-checking bench for rotate_controller (ROUNDS=1 and ROUNDS=3 instances)
module tb_rotate_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] start_v, abort_v;
  logic [1:0] co64, co25;
  logic [1:0] busy_w, done_w, r64_w, r25_w, e64_w, e25_w, inreg_w, wr1_w, wr2_w;

  // Datapath counter models: slice 0..63, lane 7..31.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int R = (g == 0) ? 1 : 3;
    logic [5:0] cnt64;
    logic [4:0] cnt25;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt64 <= 6'd0;
        cnt25 <= 5'd7;
      end else begin
        if (r64_w[g])      cnt64 <= 6'd0;
        else if (e64_w[g]) cnt64 <= cnt64 + 6'd1;
        if (r25_w[g])      cnt25 <= 5'd7;
        else if (e25_w[g]) cnt25 <= cnt25 + 5'd1;
      end
    end

    assign co64[g] = (cnt64 == 6'd63);
    assign co25[g] = (cnt25 == 5'd31);

    rotate_controller #(.ROUNDS(R)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_v[g]),
      .abort     (abort_v[g]),
      .cnt_co_64 (co64[g]),
      .cnt_co_25 (co25[g]),
      .cnt_rst_64(r64_w[g]),
      .cnt_rst_25(r25_w[g]),
      .cnt_en_64 (e64_w[g]),
      .cnt_en_25 (e25_w[g]),
      .inreg_en  (inreg_w[g]),
      .wr_en_1   (wr1_w[g]),
      .wr_en_2   (wr2_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g])
    );
  end

  // Output vector order: {busy, done, rst64, rst25, en64, en25, inreg, wr1, wr2}
  localparam logic [8:0] O_INIT  = 9'b101100000;
  localparam logic [8:0] O_LOAD  = 9'b100000100;
  localparam logic [8:0] O_ROT   = 9'b100010010;
  localparam logic [8:0] O_LANE  = 9'b101001001;
  localparam logic [8:0] O_ROUND = 9'b100100000;
  localparam logic [8:0] O_DONE  = 9'b110000000;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: an operation is a cycle index k counted from INIT (k=0).
  bit active[2];
  int k[2];

  int n_inreg[2], n_wr1[2], n_wr2[2], n_round[2], n_done[2];
  int init_cyc[2], done_cyc[2];

  function automatic int rounds_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int last_k(input int i);
    return 1 + rounds_of(i) * 1651;
  endfunction

  function automatic logic [8:0] exp_out(input bit act, input int kk, input int i);
    int j, m;
    if (!act) return 9'b0;
    if (kk == 0) return O_INIT;
    if (kk == last_k(i)) return O_DONE;
    j = (kk - 1) % 1651;
    if (j == 1650) return O_ROUND;
    m = j % 66;
    if (m == 0) return O_LOAD;
    if (m <= 64) return O_ROT;
    return O_LANE;
  endfunction

  function automatic logic [8:0] dut_out(input int i);
    return {busy_w[i], done_w[i], r64_w[i], r25_w[i], e64_w[i], e25_w[i],
            inreg_w[i], wr1_w[i], wr2_w[i]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    if (rst) active[i] = 1'b0;
    else if (active[i]) begin
      if (abort_v[i])            active[i] = 1'b0;
      else if (k[i] == last_k(i)) active[i] = 1'b0;
      else                       k[i]++;
    end else if (start_v[i]) begin
      active[i] = 1'b1;
      k[i]      = 0;
    end
  endtask

  task automatic compare(input int i);
    logic [8:0] e, d;
    e = exp_out(active[i], k[i], i);
    d = dut_out(i);
    total++;
    if (d !== e) begin
      bad++;
      $display("FAIL out%0d cyc=%0d: got %b expected %b", i, cyc, d, e);
    end
    total++;
    if ((wr1_w[i] & wr2_w[i]) || (done_w[i] && !busy_w[i])) begin
      bad++;
      $display("FAIL excl%0d cyc=%0d: got wr1=%b wr2=%b done=%b busy=%b expected exclusive",
               i, cyc, wr1_w[i], wr2_w[i], done_w[i], busy_w[i]);
    end
    if (inreg_w[i]) n_inreg[i]++;
    if (wr1_w[i])   n_wr1[i]++;
    if (wr2_w[i])   n_wr2[i]++;
    if (busy_w[i] && r25_w[i] && !r64_w[i]) n_round[i]++;
    if (busy_w[i] && r25_w[i] && r64_w[i])  init_cyc[i] = cyc;
    if (done_w[i]) begin
      n_done[i]++;
      done_cyc[i] = cyc;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) compare(i);
  endtask

  task automatic clear_stats(input int i);
    n_inreg[i] = 0; n_wr1[i] = 0; n_wr2[i] = 0; n_round[i] = 0; n_done[i] = 0;
    init_cyc[i] = -1; done_cyc[i] = -1;
  endtask

  task automatic run_until_done(input int i, input int budget);
    int n;
    n = 0;
    while (!done_w[i] && n < budget) begin
      cycle();
      n++;
    end
    chk($sformatf("done_seen%0d", i), int'(done_w[i]), 1);
  endtask

  initial begin
    rst     = 1'b1;
    start_v = 2'b00;
    abort_v = 2'b00;
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0;
      k[i]      = 0;
      clear_stats(i);
    end

    // Reset state
    repeat (2) cycle();
    chk("reset_out0", int'(dut_out(0)), 0);
    chk("reset_out1", int'(dut_out(1)), 0);
    rst = 1'b0;
    cycle();

    // Nominal, ROUNDS=1
    clear_stats(0);
    start_v[0] = 1'b1;
    cycle();
    start_v[0] = 1'b0;
    run_until_done(0, 2000);
    chk("nom_inreg", n_inreg[0], 25);
    chk("nom_wr1", n_wr1[0], 1600);
    chk("nom_wr2", n_wr2[0], 25);
    chk("nom_rounds", n_round[0], 1);
    chk("nom_latency", done_cyc[0] - init_cyc[0], 1652);
    cycle();
    chk("nom_idle_busy", int'(busy_w[0]), 0);

    // Multi-round, ROUNDS=3
    clear_stats(1);
    start_v[1] = 1'b1;
    cycle();
    start_v[1] = 1'b0;
    run_until_done(1, 6000);
    chk("mr_rounds", n_round[1], 3);
    chk("mr_wr2", n_wr2[1], 75);
    chk("mr_inreg", n_inreg[1], 75);
    chk("mr_latency", done_cyc[1] - init_cyc[1], 4954);
    cycle();

    // Start held for the whole operation
    clear_stats(0);
    start_v[0] = 1'b1;
    cycle();
    run_until_done(0, 2000);
    chk("hold_done_count", n_done[0], 1);
    cycle();
    chk("hold_idle_busy", int'(busy_w[0]), 0);
    cycle();
    chk("hold_reinit", int'({busy_w[0], r64_w[0], r25_w[0]}), 7);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b1;
    cycle();
    abort_v[0] = 1'b0;
    chk("hold_abort_busy", int'(busy_w[0]), 0);
    repeat (3) cycle();
    chk("hold_done_final", n_done[0], 1);

    // Abort at lane 10, slice 30
    clear_stats(0);
    start_v[0] = 1'b1;
    cycle();
    start_v[0] = 1'b0;
    repeat (626) cycle();
    chk("abort_slice", int'(g_dut[0].cnt64), 30);
    chk("abort_lane", int'(g_dut[0].cnt25), 16);
    chk("abort_in_rot", int'(wr1_w[0]), 1);
    abort_v[0] = 1'b1;
    cycle();
    abort_v[0] = 1'b0;
    chk("abort_idle", int'({busy_w[0], wr1_w[0], wr2_w[0]}), 0);
    repeat (5) cycle();
    chk("abort_no_done", n_done[0], 0);
    // abort together with start while idle must not block the start
    clear_stats(0);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    cycle();
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    chk("abort_idle_start", int'({busy_w[0], r64_w[0], r25_w[0]}), 7);
    run_until_done(0, 2000);
    chk("abort_restart_latency", done_cyc[0] - init_cyc[0], 1652);
    cycle();

    // Asynchronous reset during ROT, then start on the first edge after release
    clear_stats(0);
    clear_stats(1);
    start_v = 2'b11;
    cycle();
    start_v = 2'b00;
    repeat (100) cycle();
    chk("pre_rst_rot", int'(wr1_w[0] & wr1_w[1]), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out0", int'(dut_out(0)), 0);
    chk("async_rst_out1", int'(dut_out(1)), 0);
    cycle();
    rst        = 1'b0;
    start_v[0] = 1'b1;
    cycle();
    start_v[0] = 1'b0;
    chk("post_rst_busy1", int'(busy_w[1]), 0);
    chk("post_rst_init0", int'({busy_w[0], r64_w[0], r25_w[0]}), 7);
    run_until_done(0, 2000);
    chk("post_rst_latency", done_cyc[0] - init_cyc[0], 1652);
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotate_controller.md
ROTATE_CONTROLLER -- requirements
Module: rotate_controller

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 1, meaning the number of complete rotate passes (1..24) per start.
REQ-002 The block SHALL have port clk, input, 1, meaning the system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, meaning a request to begin an operation; it is sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1, meaning a synchronous cancel of the operation in progress.
REQ-006 The block SHALL have port cnt_co_64, input, 1, meaning the terminal count of the datapath slice counter.
REQ-007 The block SHALL have port cnt_co_25, input, 1, meaning the terminal count of the datapath lane counter.
REQ-008 The block SHALL have ports cnt_rst_64, cnt_rst_25, cnt_en_64, cnt_en_25, output, 1 each, meaning the datapath counter controls.
REQ-009 The block SHALL have ports inreg_en, wr_en_1, wr_en_2, output, 1 each, meaning the datapath input-register load and the memory write strobes.
REQ-010 The block SHALL have port busy, output, 1, meaning an operation is in progress (any state except IDLE).
REQ-011 The block SHALL have port done, output, 1, meaning a one-cycle completion pulse.

Function
REQ-012 The block SHALL be a Moore FSM with states IDLE, INIT, LOAD, ROT, LANE, ROUND and DONE; all outputs SHALL be decoded from the state alone.
REQ-013 IDLE SHALL drive all outputs 0 and SHALL move to INIT when start=1; otherwise it SHALL remain in IDLE.
REQ-014 INIT SHALL last 1 cycle, SHALL assert cnt_rst_64=1 and cnt_rst_25=1, SHALL clear the internal round counter to 0, and SHALL go to LOAD.
REQ-015 LOAD SHALL last 1 cycle, SHALL assert inreg_en=1, and SHALL go to ROT.
REQ-016 ROT SHALL assert wr_en_1=1 and cnt_en_64=1 every cycle, SHALL remain in ROT while cnt_co_64=0, and SHALL go to LANE in the cycle after a cycle with cnt_co_64=1 (64 ROT cycles per lane).
REQ-017 LANE SHALL last 1 cycle and SHALL assert wr_en_2=1, cnt_en_25=1 and cnt_rst_64=1.
REQ-018 From LANE, the FSM SHALL go to ROUND if cnt_co_25=1 in that cycle, else to LOAD.
REQ-019 ROUND SHALL last 1 cycle, SHALL assert cnt_rst_25=1, and SHALL increment the round counter (5 bits, no wrap in legal use).
REQ-020 From ROUND, the FSM SHALL go to DONE if the incremented round count equals ROUNDS, else to LOAD.
REQ-021 DONE SHALL assert done=1 for exactly 1 cycle, with busy=1, and SHALL then go to IDLE.
REQ-022 start asserted in any non-IDLE state SHALL be ignored and SHALL NOT be queued.
REQ-023 abort=1 in any non-IDLE state SHALL force the next state to IDLE with no done pulse; write strobes SHALL be 0 from the next cycle onward.
REQ-024 abort SHALL take priority over every other transition; abort in IDLE SHALL have no effect, including when start is high in the same cycle.
REQ-025 wr_en_1 and wr_en_2 SHALL never be asserted in the same cycle.
REQ-026 cnt_co_64 and cnt_co_25 SHALL be ignored outside ROT and LANE, respectively.
REQ-027 The start-to-done latency SHALL be 1 + ROUNDS*(25*66 + 1) cycles from the INIT cycle through the DONE cycle, i.e. 1652 cycles for ROUNDS=1.

Reset
REQ-028 Asserting rst SHALL immediately force state IDLE and round counter 0, and SHALL drive all outputs 0, including mid-operation.
REQ-029 After rst deasserts, the block SHALL accept start on the first rising clock edge.

Verification
REQ-030 Reset scenario: rst pulse during ROT -> all outputs 0 asynchronously, and busy=0 on the first clock after release.
REQ-031 Nominal scenario: ROUNDS=1 with a counter model (cnt64 0..63, cnt25 7..31) and a 1-cycle start -> 25 inreg_en pulses, 1600 wr_en_1 cycles, 25 wr_en_2 pulses, and a done pulse 1652 cycles after the INIT cycle.
REQ-032 Multi-round scenario: ROUNDS=3 -> 3 ROUND visits, 75 wr_en_2 pulses, and done on cycle 1 + 3*1651 = 4954.
REQ-033 Start-ignore scenario: start held high for the whole operation -> exactly one done pulse, then a new INIT on the cycle after IDLE is re-entered.
REQ-034 Abort scenario: abort at lane 10, slice 30 -> IDLE next cycle, no done pulse, then a subsequent start completes normally in 1652 cycles.
REQ-035 Exclusivity scenario: an assertion checker on every cycle -> wr_en_1&wr_en_2=0, and done=1 only together with busy=1.
